reg_file_32x32: RTL and testbench

REG_FILE_32X32 -- requirements
Module: reg_file_32x32

---
 rtl/reg_file_32x32.sv | 70 +++++++
 tb/tb_reg_file_32x32.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 32-entry register file with a one-hot write select and two registered read ports
// Optional write-first bypass: define RF_WRITE_BYPASS_EN (default build is read-first).
module reg_file_32x32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [31:0]      wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rd_valid,
  output logic             sel_err
);

  logic [WIDTH-1:0] regs [32];
  logic             sel_nonzero;
  logic             sel_multi;
  logic             write_ok;
  logic             bypass1;
  logic             bypass2;
  logic [WIDTH-1:0] rd1_next;
  logic [WIDTH-1:0] rd2_next;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits were set.
  assign sel_nonzero = |wsel;
  assign sel_multi   = |(wsel & (wsel - 32'd1));
  assign write_ok    = reg_write && sel_nonzero && !sel_multi;

`ifdef RF_WRITE_BYPASS_EN
  assign bypass1 = write_ok && wsel[ra1];
  assign bypass2 = write_ok && wsel[ra2];
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  // Address 0 is forced to zero last, so it also overrides any bypass of bit 0.
  always_comb begin
    rd1_next = bypass1 ? wdata : regs[ra1];
    rd2_next = bypass2 ? wdata : regs[ra2];
    if (ra1 == 5'd0) rd1_next = '0;
    if (ra2 == 5'd0) rd2_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rd1      <= '0;
      rd2      <= '0;
      rd_valid <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (write_ok && wsel[i]) regs[i] <= wdata;
      end
      if (reg_write && sel_multi) sel_err <= 1'b1;
      rd_valid <= re;
      if (re) begin
        rd1 <= rd1_next;
        rd2 <= rd2_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb/tb_reg_file_32x32.sv - directed vector bench for reg_file_32x32
module tb_reg_file_32x32;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic [31:0] wsel;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        rd_valid;
  logic        sel_err;

  int total = 0;
  int bad   = 0;

  reg_file_32x32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .wsel(wsel), .wdata(wdata),
    .re(re), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd_valid(rd_valid), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] wsel;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one clock edge, then sample just after it.
  task automatic cyc(input logic w, input logic [31:0] s, input logic [31:0] d,
                     input logic r, input logic [4:0] a1, input logic [4:0] a2);
    reg_write = w; wsel = s; wdata = d; re = r; ra1 = a1; ra2 = a2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  logic [31:0] exp32;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 32'h0,          32'h0,          1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         32'h0,         1'b1, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0,          1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0,          1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,         32'h0,         1'b1, 5'd0, 5'd0, 32'h0,          32'h0,          1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0002, 32'h1111_1111, 1'b0, 5'd0, 5'd0, 32'h0,          32'h0,          1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0004, 32'h2222_2222, 1'b1, 5'd1, 5'd5, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0,         32'hAAAA_AAAA, 1'b1, 5'd2, 5'd2, 32'h2222_2222, 32'h2222_2222, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0006, 32'h0,         1'b0, 5'd0, 5'd0, 32'h2222_2222, 32'h2222_2222, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_0006, 32'h1234_5678, 1'b1, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         32'h0,         1'b1, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b1};

    rst = 1'b1; reg_write = 1'b0; wsel = '0; wdata = '0; re = 1'b0; ra1 = '0; ra2 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset rd1", rd1, 32'h0);
    check("reset rd2", rd2, 32'h0);
    check("reset rd_valid", {31'h0, rd_valid}, 32'h0);
    check("reset sel_err", {31'h0, sel_err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].rw, vecs[i].wsel, vecs[i].wdata, vecs[i].re, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("vec%0d rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("vec%0d rd_valid", i), {31'h0, rd_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d sel_err", i), {31'h0, sel_err}, {31'h0, vecs[i].e_err});
    end

    // sticky error survives idle cycles, then reset clears everything
    for (int i = 0; i < 10; i++) idle();
    check("sel_err sticky", {31'h0, sel_err}, 32'h1);
    rst = 1'b1;
    cyc(1'b1, 32'h0000_0002, 32'h5555_5555, 1'b1, 5'd1, 5'd2);
    rst = 1'b0;
    check("rst clears sel_err", {31'h0, sel_err}, 32'h0);
    check("rst rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst rd1", rd1, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 5'd5);
    check("post-rst r1", rd1, 32'h0);
    check("post-rst r5", rd2, 32'h0);
    check("post-rst valid", {31'h0, rd_valid}, 32'h1);

    // same-cycle read/write of r7
    cyc(1'b1, 32'h0000_0080, 32'h0000_0011, 1'b0, 5'd0, 5'd0);
    cyc(1'b1, 32'h0000_0080, 32'h0000_0022, 1'b1, 5'd7, 5'd0);
`ifdef RF_WRITE_BYPASS_EN
    exp32 = 32'h0000_0022;
`else
    exp32 = 32'h0000_0011;
`endif
    check("r7 same-cycle rd1", rd1, exp32);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd7);
    check("r7 next-cycle rd1", rd1, 32'h0000_0022);
    check("r7 next-cycle rd2", rd2, 32'h0000_0022);

    // fill r1..r31 with their index
    for (int i = 1; i < 32; i++) cyc(1'b1, 32'h1 << i, 32'(i), 1'b0, 5'd0, 5'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd1);
    check("fill rd1 r31", rd1, 32'd31);
    check("fill rd2 r1", rd2, 32'd1);
    check("fill valid", {31'h0, rd_valid}, 32'h1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 5'd16, 5'd17);
    check("hold valid", {31'h0, rd_valid}, 32'h0);
    check("hold rd1", rd1, 32'd31);
    check("hold rd2", rd2, 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd16, 5'd17);
    check("fill rd1 r16", rd1, 32'd16);
    check("fill rd2 r17", rd2, 32'd17);

    // reset right after a read
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd30);
    check("pre-rst rd1", rd1, 32'd31);
    rst = 1'b1;
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd30);
    rst = 1'b0;
    check("mid-rst rd1", rd1, 32'h0);
    check("mid-rst rd2", rd2, 32'h0);
    check("mid-rst valid", {31'h0, rd_valid}, 32'h0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 5'd31, 5'd30);
    check("after-rst r31", rd1, 32'h0);
    check("after-rst r30", rd2, 32'h0);
    check("after-rst valid", {31'h0, rd_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
